// File: rtl/nvdla_glb_intr_pkg.sv
// Shared constants and helpers for the GLB CACC done-interrupt collector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nvdla_glb_intr_pkg;

    // Number of CACC register groups (ping/pong); bit i of every vector is group i.
    localparam int NUM_GRP = 2;
    // Width of the per-group saturating missed-done counter.
    localparam int MISS_W  = 8;

    // Group index constants.
    localparam int GRP_PING = 0;
    localparam int GRP_PONG = 1;

    // Mask resets to all-masked so nothing interrupts before software opts in.
    localparam logic [NUM_GRP-1:0] MASK_RST = {NUM_GRP{1'b1}};

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
        logic [MISS_W-1:0] max_v;
        max_v = '1;
        return (v == max_v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/nvdla_glb_intr_grp_cell.sv
// One CACC group's sticky status bit, overflow bit and saturating miss counter.
// Latency: 1 cycle from done/set/clear strobe to updated state.
// Backpressure: none; every strobe is consumed in the cycle it is presented.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   done_i     : hardware done pulse for this group
//   set_i      : software set strobe for this group
//   clr_i      : W1C strobe for this group (status and overflow)
//   miss_clr_i : clear of the miss counter
//   status_o, ovf_o, miss_cnt_o : registered state
module nvdla_glb_intr_grp_cell
    import nvdla_glb_intr_pkg::*;
(
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              done_i,
    input  logic              set_i,
    input  logic              clr_i,
    input  logic              miss_clr_i,
    output logic              status_o,
    output logic              ovf_o,
    output logic [MISS_W-1:0] miss_cnt_o
);

    logic              status_q, status_d;
    logic              ovf_q,    ovf_d;
    logic [MISS_W-1:0] cnt_q,    cnt_d;
    logic              ovf_evt;

    // A done landing on an already-set status is a lost event, unless the same
    // cycle clears the bit: then the done simply re-arms the status.
    // Software set is never counted.
    assign ovf_evt = done_i & status_q & ~clr_i;

    always_comb begin
        status_d = status_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;

        // Set (hardware or software) takes priority over a same-cycle clear.
        if (done_i || set_i) begin
            status_d = 1'b1;
        end else if (clr_i) begin
            status_d = 1'b0;
        end

        if (clr_i) begin
            ovf_d = 1'b0;
        end else if (ovf_evt) begin
            ovf_d = 1'b1;
        end

        // Counter clear wins over a coincident increment.
        if (miss_clr_i) begin
            cnt_d = '0;
        end else if (ovf_evt) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            status_q <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            status_q <= status_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign status_o   = status_q;
    assign ovf_o      = ovf_q;
    assign miss_cnt_o = cnt_q;

endmodule

// File: rtl/nvdla_glb_cacc_intr_rcv.sv
// GLB receive-side collector for the CACC done interrupt: per-group sticky status,
// mask, W1C/set, overflow tracking and a registered level interrupt.
// Latency: done pulse -> status +1 cycle -> cacc_done_intr +2 cycles. Backpressure: none.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   cacc2glb_done_intr_dst_pd        : retimed done pulses, one bit per group
//   sts_clr_en/data, sts_set_en/data : status W1C and software set strobes
//   msk_wr_en/data                   : mask register write (1 = masked)
//   miss_clr                         : clear all miss counters
//   intr_status, intr_mask, intr_ovf, miss_cnt_g0/g1, cacc_done_intr : status outputs
module nvdla_glb_cacc_intr_rcv
    import nvdla_glb_intr_pkg::*;
(
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rstn,
    input  logic [NUM_GRP-1:0] cacc2glb_done_intr_dst_pd,
    input  logic               sts_clr_en,
    input  logic [NUM_GRP-1:0] sts_clr_data,
    input  logic               sts_set_en,
    input  logic [NUM_GRP-1:0] sts_set_data,
    input  logic               msk_wr_en,
    input  logic [NUM_GRP-1:0] msk_wr_data,
    input  logic               miss_clr,
    output logic [NUM_GRP-1:0] intr_status,
    output logic [NUM_GRP-1:0] intr_mask,
    output logic [NUM_GRP-1:0] intr_ovf,
    output logic [MISS_W-1:0]  miss_cnt_g0,
    output logic [MISS_W-1:0]  miss_cnt_g1,
    output logic               cacc_done_intr
);

    logic [NUM_GRP-1:0] mask_q, mask_d;
    logic               intr_q, intr_d;
    logic [NUM_GRP-1:0] clr_vec;
    logic [NUM_GRP-1:0] set_vec;
    logic [NUM_GRP-1:0] status_w;
    logic [NUM_GRP-1:0] ovf_w;
    logic [MISS_W-1:0]  cnt_w [NUM_GRP];

    // Qualify the data words with their strobes once, then slice per group.
    assign clr_vec = sts_clr_en ? sts_clr_data : '0;
    assign set_vec = sts_set_en ? sts_set_data : '0;

    for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
        nvdla_glb_intr_grp_cell u_cell (
            .nvdla_core_clk  (nvdla_core_clk),
            .nvdla_core_rstn (nvdla_core_rstn),
            .done_i          (cacc2glb_done_intr_dst_pd[g]),
            .set_i           (set_vec[g]),
            .clr_i           (clr_vec[g]),
            .miss_clr_i      (miss_clr),
            .status_o        (status_w[g]),
            .ovf_o           (ovf_w[g]),
            .miss_cnt_o      (cnt_w[g])
        );
    end

    assign mask_d = msk_wr_en ? msk_wr_data : mask_q;
    // Built from registered status and mask, so the interrupt trails them by one cycle.
    assign intr_d = |(status_w & ~mask_q);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            mask_q <= MASK_RST;
            intr_q <= 1'b0;
        end else begin
            mask_q <= mask_d;
            intr_q <= intr_d;
        end
    end

    assign intr_status    = status_w;
    assign intr_mask      = mask_q;
    assign intr_ovf       = ovf_w;
    assign miss_cnt_g0    = cnt_w[GRP_PING];
    assign miss_cnt_g1    = cnt_w[GRP_PONG];
    assign cacc_done_intr = intr_q;

endmodule

// File: tb/tb_nvdla_glb_cacc_intr_rcv.sv
module tb_nvdla_glb_cacc_intr_rcv;

    logic       clk;
    logic       rstn;
    logic [1:0] pd;
    logic       clr_en;
    logic [1:0] clr_data;
    logic       set_en;
    logic [1:0] set_data;
    logic       msk_en;
    logic [1:0] msk_data;
    logic       mclr;
    logic [1:0] status;
    logic [1:0] mask;
    logic [1:0] ovf;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic       intr;

    int nvec;
    int nerr;

    nvdla_glb_cacc_intr_rcv dut (
        .nvdla_core_clk            (clk),
        .nvdla_core_rstn           (rstn),
        .cacc2glb_done_intr_dst_pd (pd),
        .sts_clr_en                (clr_en),
        .sts_clr_data              (clr_data),
        .sts_set_en                (set_en),
        .sts_set_data              (set_data),
        .msk_wr_en                 (msk_en),
        .msk_wr_data               (msk_data),
        .miss_clr                  (mclr),
        .intr_status               (status),
        .intr_mask                 (mask),
        .intr_ovf                  (ovf),
        .miss_cnt_g0               (cnt0),
        .miss_cnt_g1               (cnt1),
        .cacc_done_intr            (intr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pd = 2'b00; clr_en = 1'b0; clr_data = 2'b00; set_en = 1'b0; set_data = 2'b00;
        msk_en = 1'b0; msk_data = 2'b00; mclr = 1'b0;
    endtask

    // Clear all status/ovf bits and miss counters, leave the mask alone.
    task automatic cleanup();
        idle();
        clr_en = 1'b1; clr_data = 2'b11; mclr = 1'b1;
        cyc();
        idle();
        cyc();
    endtask

    task automatic test_reset();
        idle();
        rstn = 1'b0;
        #12;
        nvec++; if (status !== 2'b00) begin nerr++; $display("FAIL reset_status got=%b exp=00", status); end
        nvec++; if (mask !== 2'b11) begin nerr++; $display("FAIL reset_mask got=%b exp=11", mask); end
        nvec++; if (ovf !== 2'b00) begin nerr++; $display("FAIL reset_ovf got=%b exp=00", ovf); end
        nvec++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin nerr++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt0, cnt1); end
        nvec++; if (intr !== 1'b0) begin nerr++; $display("FAIL reset_intr got=%b exp=0", intr); end
        cyc();
        rstn = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        msk_en = 1'b1; msk_data = 2'b00;
        cyc();
        idle();
        nvec++; if (mask !== 2'b00) begin nerr++; $display("FAIL basic_mask got=%b exp=00", mask); end
        pd = 2'b01;
        cyc();
        idle();
        nvec++; if (status !== 2'b01) begin nerr++; $display("FAIL basic_status_n1 got=%b exp=01", status); end
        nvec++; if (intr !== 1'b0) begin nerr++; $display("FAIL basic_intr_n1 got=%b exp=0", intr); end
        cyc();
        nvec++; if (intr !== 1'b1) begin nerr++; $display("FAIL basic_intr_n2 got=%b exp=1", intr); end
        clr_en = 1'b1; clr_data = 2'b01;
        cyc();
        idle();
        nvec++; if (status !== 2'b00) begin nerr++; $display("FAIL basic_w1c_status got=%b exp=00", status); end
        nvec++; if (intr !== 1'b1) begin nerr++; $display("FAIL basic_w1c_intr_n1 got=%b exp=1", intr); end
        cyc();
        nvec++; if (intr !== 1'b0) begin nerr++; $display("FAIL basic_w1c_intr_n2 got=%b exp=0", intr); end
    endtask

    task automatic test_masked();
        msk_en = 1'b1; msk_data = 2'b11;
        cyc();
        idle();
        pd = 2'b10;
        cyc();
        idle();
        nvec++; if (status !== 2'b10) begin nerr++; $display("FAIL masked_status got=%b exp=10", status); end
        cyc();
        nvec++; if (intr !== 1'b0) begin nerr++; $display("FAIL masked_intr got=%b exp=0", intr); end
        msk_en = 1'b1; msk_data = 2'b01;
        cyc();
        idle();
        nvec++; if (mask !== 2'b01 || intr !== 1'b0) begin nerr++; $display("FAIL unmask_n1 got mask=%b intr=%b exp mask=01 intr=0", mask, intr); end
        cyc();
        nvec++; if (intr !== 1'b1) begin nerr++; $display("FAIL unmask_n2 got=%b exp=1", intr); end
        cleanup();
        nvec++; if (intr !== 1'b0 || status !== 2'b00) begin nerr++; $display("FAIL masked_cleanup got status=%b intr=%b exp 00/0", status, intr); end
    endtask

    task automatic test_overflow();
        pd = 2'b01;
        cyc();
        nvec++; if (status !== 2'b01 || ovf !== 2'b00) begin nerr++; $display("FAIL ovf_first got status=%b ovf=%b exp 01/00", status, ovf); end
        cyc();
        nvec++; if (ovf !== 2'b01 || cnt0 !== 8'd1) begin nerr++; $display("FAIL ovf_b2b got ovf=%b cnt0=%0d exp 01/1", ovf, cnt0); end
        for (int i = 0; i < 300; i++) cyc();
        idle();
        nvec++; if (cnt0 !== 8'd255) begin nerr++; $display("FAIL ovf_saturate got=%0d exp=255", cnt0); end
        nvec++; if (cnt1 !== 8'd0) begin nerr++; $display("FAIL ovf_other_grp got=%0d exp=0", cnt1); end
        // W1C must leave the counter untouched.
        clr_en = 1'b1; clr_data = 2'b01;
        cyc();
        idle();
        nvec++; if (ovf !== 2'b00 || status !== 2'b00 || cnt0 !== 8'd255) begin nerr++; $display("FAIL ovf_w1c got ovf=%b status=%b cnt0=%0d exp 00/00/255", ovf, status, cnt0); end
        mclr = 1'b1;
        cyc();
        idle();
        nvec++; if (cnt0 !== 8'd0) begin nerr++; $display("FAIL miss_clr got=%0d exp=0", cnt0); end
        // miss_clr coincident with an overflow increment ends at zero.
        pd = 2'b01;
        cyc();
        mclr = 1'b1;
        cyc();
        idle();
        nvec++; if (cnt0 !== 8'd0 || ovf !== 2'b01) begin nerr++; $display("FAIL miss_clr_collide got cnt0=%0d ovf=%b exp 0/01", cnt0, ovf); end
        cleanup();
    endtask

    task automatic test_collision();
        pd = 2'b01;
        cyc();
        cyc();
        idle();
        nvec++; if (ovf !== 2'b01 || cnt0 !== 8'd1) begin nerr++; $display("FAIL coll_setup got ovf=%b cnt0=%0d exp 01/1", ovf, cnt0); end
        pd = 2'b01; clr_en = 1'b1; clr_data = 2'b01;
        cyc();
        idle();
        nvec++; if (status !== 2'b01 || ovf !== 2'b00 || cnt0 !== 8'd1) begin nerr++; $display("FAIL coll_done_clr got status=%b ovf=%b cnt0=%0d exp 01/00/1", status, ovf, cnt0); end
        // Software set on an already-set bit is never an overflow.
        set_en = 1'b1; set_data = 2'b01;
        cyc();
        idle();
        nvec++; if (ovf !== 2'b00 || cnt0 !== 8'd1) begin nerr++; $display("FAIL sw_set_no_ovf got ovf=%b cnt0=%0d exp 00/1", ovf, cnt0); end
        set_en = 1'b1; set_data = 2'b10; clr_en = 1'b1; clr_data = 2'b11;
        cyc();
        idle();
        nvec++; if (status !== 2'b10) begin nerr++; $display("FAIL set_beats_clr got=%b exp=10", status); end
        cleanup();
    endtask

    task automatic test_dual();
        msk_en = 1'b1; msk_data = 2'b00;
        cyc();
        idle();
        pd = 2'b11;
        cyc();
        idle();
        nvec++; if (status !== 2'b11 || ovf !== 2'b00) begin nerr++; $display("FAIL dual_status got status=%b ovf=%b exp 11/00", status, ovf); end
        cyc();
        nvec++; if (intr !== 1'b1) begin nerr++; $display("FAIL dual_intr got=%b exp=1", intr); end
        clr_en = 1'b1; clr_data = 2'b10;
        cyc();
        idle();
        nvec++; if (status !== 2'b01) begin nerr++; $display("FAIL dual_w1c got=%b exp=01", status); end
        cyc();
        nvec++; if (intr !== 1'b1) begin nerr++; $display("FAIL dual_intr_hold got=%b exp=1", intr); end
    endtask

    task automatic test_async_reset();
        // Enters with status=01, mask=00.
        pd = 2'b11;
        cyc();
        pd = 2'b01;
        cyc();
        nvec++; if (status !== 2'b11 || ovf !== 2'b01 || cnt0 !== 8'd2) begin nerr++; $display("FAIL arst_setup got status=%b ovf=%b cnt0=%0d exp 11/01/2", status, ovf, cnt0); end
        #2;
        rstn = 1'b0;
        #1;
        nvec++; if (status !== 2'b00 || ovf !== 2'b00 || mask !== 2'b11) begin nerr++; $display("FAIL arst_regs got status=%b ovf=%b mask=%b exp 00/00/11", status, ovf, mask); end
        nvec++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0 || intr !== 1'b0) begin nerr++; $display("FAIL arst_cnt_intr got cnt=%0d/%0d intr=%b exp 0/0/0", cnt0, cnt1, intr); end
        cyc();
        idle();
        rstn = 1'b1;
        cyc();
        cyc();
        nvec++; if (status !== 2'b00 || intr !== 1'b0 || mask !== 2'b11) begin nerr++; $display("FAIL arst_release got status=%b intr=%b mask=%b exp 00/0/11", status, intr, mask); end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rstn = 1'b0;
        idle();
        test_reset();
        test_basic();
        test_masked();
        test_overflow();
        test_collision();
        test_dual();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/nvdla_glb_cacc_intr_rcv.md
# nvdla_glb_cacc_intr_rcv

Receive-side interrupt collector in GLB for the CACC done-interrupt path. It consumes the retimed 2-bit done pulse vector, one bit per CACC register group (ping/pong). It keeps sticky per-group status with software mask, write-1-to-clear, software set and overflow tracking. It drives a registered, level-sensitive core interrupt contribution.

## Interface
- NUM_GRP, 2, number of CACC register groups (bit i of every vector = group i)
- MISS_W, 8, width of per-group saturating missed-done counter
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  reset, asynchronous, active-low
- cacc2glb_done_intr_dst_pd  in  NUM_GRP  done pulses; each high cycle = one done event for that group
- sts_clr_en  in  1  write strobe, status W1C
- sts_clr_data  in  NUM_GRP  1 = clear status (and overflow) bit i
- sts_set_en  in  1  write strobe, software set
- sts_set_data  in  NUM_GRP  1 = set status bit i
- msk_wr_en  in  1  write strobe, mask register
- msk_wr_data  in  NUM_GRP  1 = group masked
- miss_clr  in  1  single-cycle clear of all miss counters
- intr_status  out  NUM_GRP  sticky done status
- intr_mask  out  NUM_GRP  current mask
- intr_ovf  out  NUM_GRP  sticky: done arrived while status already set
- miss_cnt_g0, miss_cnt_g1  out  MISS_W  saturating count of overflowing done events per group
- cacc_done_intr  out  1  registered OR of (status & ~mask)

## Operation
- Reset values: intr_status=0, intr_mask={NUM_GRP{1'b1}} (all masked), intr_ovf=0, miss counters=0, cacc_done_intr=0.
- Per-group status next-state, in priority order:
  - hardware done pulse or software set → 1 (set wins over a same-cycle clear);
  - else W1C with bit=1 → 0;
  - else hold.
- Overflow: a done pulse for group i while intr_status[i]==1, with no same-cycle clear of bit i, sets intr_ovf[i] and increments miss_cnt_gi.
  - A done pulse coinciding with a clear of bit i is not an overflow: status stays 1, ovf unchanged.
- intr_ovf[i] clears with the same W1C bit as status. If a clear and an overflow event coincide, ovf ends at 0 (the event re-sets status only).
- Miss counters:
  - saturate at 2^MISS_W-1; no wrap;
  - miss_clr zeroes all counters. If it coincides with an increment, the result is 0.
  - W1C does not touch the counters.
- Software set never counts as overflow and never increments counters.
- Mask only gates cacc_done_intr; status still captures while masked. Unmasking with status set raises the interrupt.
- Simultaneous pulses on both groups are processed independently in the same cycle.

## Timing
- Done pulse at cycle N → intr_status[i]=1 at N+1 → cacc_done_intr=1 at N+2.
- W1C or mask write at cycle N → status/mask updated at N+1 → cacc_done_intr updated at N+2.
- Back-to-back pulses N, N+1 on one group: status set at N+1. The pulse at N+1 is an overflow: ovf=1 and count=1 at N+2.
- Reset assertion mid-operation asynchronously forces all reset values; no pending event survives.
- No backpressure: every input pulse is consumed in its cycle.

## Structure
- Shared package nvdla_glb_intr_pkg:
  - NUM_GRP, MISS_W;
  - group index constants GRP_PING=0, GRP_PONG=1;
  - reset constant MASK_RST={NUM_GRP{1'b1}}.
- Sub-module nvdla_glb_intr_grp_cell, instantiated once per group. It holds one group's status bit, ovf bit and saturating miss counter, with the set/clear priority above.
- The top level holds the mask register, the per-group slicing of the strobes and the registered OR/AND reduction to cacc_done_intr.

## Test plan
- Reset, then unmask both (msk_wr_data=2'b00), then pulse pd=2'b01 at N → status=01 at N+1, cacc_done_intr=1 at N+2; W1C 2'b01 → status=00, intr low two cycles later.
- Masked capture: mask=2'b11, pulse pd=2'b10 → status=10, cacc_done_intr stays 0; write mask=2'b01 → intr=1 two cycles after the write.
- Overflow: pd=2'b01 on N and N+1 → ovf=01 and miss_cnt_g0=1. Repeat 300 further pulses without clear → miss_cnt_g0 saturates at 255. miss_clr → 0.
- Set/clear collision: status[0]=1, then pd bit0 and W1C 2'b01 in the same cycle → status[0]=1, ovf[0]=0, counter unchanged.
- Dual group: pd=2'b11 in one cycle → status=11. W1C 2'b10 → status=01, and intr stays 1 while group0 is unmasked.
- Async reset asserted mid-burst with status=11, ovf=01 and counters nonzero → all outputs at reset values immediately, mask=11.
